// File: rtl/lsu_stbuf_pkg.sv
// Shared types and sizing for the DCCM committed-store buffer.
package lsu_stbuf_pkg;
    localparam int DEPTH       = 4;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 39;
    localparam int STARVE_MAX  = 8;
    localparam int STBUF_PTR_W = $clog2(DEPTH);
    localparam int STBUF_CNT_W = $clog2(DEPTH + 1);
    localparam int STARVE_W    = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:2] addr;
        logic [DATA_W-1:0] data;
    } stbuf_entry_t;
endpackage

// File: rtl/lsu_dccm_stbuf_if.sv
// Store-in / load-forward handshake between the LSU pipe and the store buffer.
interface lsu_dccm_stbuf_if
    import lsu_stbuf_pkg::*;
();
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              ld_rden;
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              ld_stall;
    logic              lsu_freeze_dc3;

    modport master (
        output st_valid, st_addr, st_data, ld_rden, ld_addr, lsu_freeze_dc3,
        input  st_ready, fwd_hit, fwd_data, ld_stall
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_rden, ld_addr, lsu_freeze_dc3,
        output st_ready, fwd_hit, fwd_data, ld_stall
    );
endinterface

// File: rtl/lsu_stbuf_fwd.sv
// Age-ordered CAM: returns the youngest valid entry whose word address matches.
module lsu_stbuf_fwd
    import lsu_stbuf_pkg::*;
(
    input  stbuf_entry_t             entries [DEPTH],
    input  logic [STBUF_PTR_W-1:0]   rd_ptr,
    input  logic [ADDR_W-1:2]        ld_word,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
);
    logic [STBUF_PTR_W-1:0] idx;

    // Walk oldest (k=0 at rd_ptr) to youngest so the last match seen wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + STBUF_PTR_W'(k);
            if (entries[idx].valid && (entries[idx].addr == ld_word)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/lsu_dccm_stbuf.sv
// Committed-store FIFO draining into the DCCM write port, with load forwarding
// and a starvation counter that forces a drain over the load pipe.
module lsu_dccm_stbuf
    import lsu_stbuf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_l,
    lsu_dccm_stbuf_if.slave        bus,
    output logic                   dccm_wren,
    output logic [ADDR_W-1:0]      dccm_wr_addr,
    output logic [DATA_W-1:0]      dccm_wr_data,
    output logic                   stbuf_empty,
    output logic                   stbuf_full,
    output logic [STBUF_CNT_W-1:0] stbuf_count
);
    stbuf_entry_t           entries [DEPTH];
    logic [STBUF_PTR_W-1:0] wr_ptr;
    logic [STBUF_PTR_W-1:0] rd_ptr;
    logic [STBUF_CNT_W-1:0] count;
    logic [STARVE_W-1:0]    starve_cnt;
    logic                   force_drain;
    logic                   push;
    logic                   pop;
    logic [DEPTH-1:0]       valid_vec;
    logic                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

    assign stbuf_count = count;
    assign stbuf_empty = (count == '0);
    assign stbuf_full  = (count == STBUF_CNT_W'(DEPTH));
    assign bus.st_ready = ~stbuf_full;

    assign force_drain = (starve_cnt == STARVE_W'(STARVE_MAX));
    assign dccm_wren   = ~stbuf_empty & ~bus.lsu_freeze_dc3 & (~bus.ld_rden | force_drain);
    assign bus.ld_stall = force_drain & ~stbuf_empty & ~bus.lsu_freeze_dc3;

    assign push = bus.st_valid & bus.st_ready;
    assign pop  = dccm_wren;

    assign dccm_wr_addr = dccm_wren ? {entries[rd_ptr].addr, 2'b00} : '0;
    assign dccm_wr_data = dccm_wren ? entries[rd_ptr].data : '0;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // push and pop never target the same slot: push needs not-full,
            // pop needs not-empty, and wr_ptr==rd_ptr only in those states
            if (pop) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                entries[wr_ptr].valid <= 1'b1;
                entries[wr_ptr].addr  <= bus.st_addr[ADDR_W-1:2];
                entries[wr_ptr].data  <= bus.st_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            starve_cnt <= '0;
        end else if (dccm_wren || stbuf_empty) begin
            starve_cnt <= '0;
        end else if (!bus.lsu_freeze_dc3 && !force_drain) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    lsu_stbuf_fwd u_fwd (
        .entries  (entries),
        .rd_ptr   (rd_ptr),
        .ld_word  (bus.ld_addr[ADDR_W-1:2]),
        .fwd_hit  (bus.fwd_hit),
        .fwd_data (bus.fwd_data)
    );

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < DEPTH; i++) valid_vec[i] = entries[i].valid;
    end

    a_count_matches_valids: assert property (
        @(posedge clk) disable iff (!rst_l) int'(count) == $countones(valid_vec)
    );
endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Directed bench for lsu_dccm_stbuf: drain, full, forwarding, starvation, freeze, reset.
module tb_lsu_dccm_stbuf;
    import lsu_stbuf_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_l = 1'b0;
    logic                   dccm_wren;
    logic [ADDR_W-1:0]      dccm_wr_addr;
    logic [DATA_W-1:0]      dccm_wr_data;
    logic                   stbuf_empty;
    logic                   stbuf_full;
    logic [STBUF_CNT_W-1:0] stbuf_count;
    int                     n_tests = 0;
    int                     n_fail  = 0;

    lsu_dccm_stbuf_if bus ();

    lsu_dccm_stbuf dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .bus          (bus),
        .dccm_wren    (dccm_wren),
        .dccm_wr_addr (dccm_wr_addr),
        .dccm_wr_data (dccm_wr_data),
        .stbuf_empty  (stbuf_empty),
        .stbuf_full   (stbuf_full),
        .stbuf_count  (stbuf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        step();
        bus.st_valid = 1'b0;
    endtask

    task automatic zero_inputs();
        bus.st_valid       = 1'b0;
        bus.st_addr        = '0;
        bus.st_data        = '0;
        bus.ld_rden        = 1'b0;
        bus.ld_addr        = '0;
        bus.lsu_freeze_dc3 = 1'b0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst_l = 1'b0;
        #2;
        rst_l = 1'b1;
        step();
    endtask

    initial begin
        zero_inputs();
        #3;
        check("rst_st_ready", 64'(bus.st_ready), 64'(1));
        check("rst_empty",    64'(stbuf_empty), 64'(1));
        check("rst_full",     64'(stbuf_full), 64'(0));
        check("rst_count",    64'(stbuf_count), 64'(0));
        check("rst_wren",     64'(dccm_wren), 64'(0));
        check("rst_wr_addr",  64'(dccm_wr_addr), 64'(0));
        check("rst_wr_data",  64'(dccm_wr_data), 64'(0));
        check("rst_fwd_hit",  64'(bus.fwd_hit), 64'(0));
        check("rst_fwd_data", 64'(bus.fwd_data), 64'(0));
        check("rst_ld_stall", 64'(bus.ld_stall), 64'(0));
        rst_l = 1'b1;
        step();

        // basic drain, then overlapped push/pop with unaligned store address
        push(16'h0010, 39'h1AB);
        check("drain_wren", 64'(dccm_wren), 64'(1));
        check("drain_addr", 64'(dccm_wr_addr), 64'h0010);
        check("drain_data", 64'(dccm_wr_data), 64'h1AB);
        check("drain_cnt",  64'(stbuf_count), 64'(1));
        push(16'h0017, 39'h2CD);
        check("pp_count",   64'(stbuf_count), 64'(1));
        check("pp_addr",    64'(dccm_wr_addr), 64'h0014);
        check("pp_data",    64'(dccm_wr_data), 64'h2CD);
        step();
        check("drain_empty", 64'(stbuf_empty), 64'(1));
        check("drain_idle",  64'(dccm_wren), 64'(0));
        check("idle_addr",   64'(dccm_wr_addr), 64'(0));

        // forwarding: youngest match wins, same-cycle push not forwarded
        do_reset();
        bus.ld_rden = 1'b1;
        push(16'h0020, 39'h11);
        push(16'h0020, 39'h22);
        bus.ld_addr = 16'h0023;
        #1;
        check("fwd_hit_young",  64'(bus.fwd_hit), 64'(1));
        check("fwd_data_young", 64'(bus.fwd_data), 64'h22);
        bus.ld_addr = 16'h0024;
        #1;
        check("fwd_miss_hit",  64'(bus.fwd_hit), 64'(0));
        check("fwd_miss_data", 64'(bus.fwd_data), 64'(0));
        bus.st_valid = 1'b1;
        bus.st_addr  = 16'h0030;
        bus.st_data  = 39'h33;
        bus.ld_addr  = 16'h0030;
        #1;
        check("fwd_no_bypass", 64'(bus.fwd_hit), 64'(0));
        step();
        bus.st_valid = 1'b0;
        #1;
        check("fwd_after_push_hit",  64'(bus.fwd_hit), 64'(1));
        check("fwd_after_push_data", 64'(bus.fwd_data), 64'h33);

        // starvation: 8 blocked cycles then one forced drain with stall
        do_reset();
        bus.ld_rden = 1'b1;
        push(16'h0050, 39'h55);
        for (int i = 0; i < STARVE_MAX; i++) begin
            check($sformatf("starve_blocked_%0d", i), 64'({dccm_wren, bus.ld_stall}), 64'(0));
            step();
        end
        check("force_wren",  64'(dccm_wren), 64'(1));
        check("force_stall", 64'(bus.ld_stall), 64'(1));
        check("force_addr",  64'(dccm_wr_addr), 64'h0050);
        step();
        check("post_force_wren",   64'(dccm_wren), 64'(0));
        check("post_force_stall",  64'(bus.ld_stall), 64'(0));
        check("post_force_starve", 64'(dut.starve_cnt), 64'(0));
        check("post_force_empty",  64'(stbuf_empty), 64'(1));

        // fill with loads blocking, then freeze; 5th store refused
        do_reset();
        bus.ld_rden = 1'b1;
        for (int i = 0; i < 4; i++) push(16'h0040 + 16'(4 * i), 39'h100 + 39'(i));
        check("full_count",  64'(stbuf_count), 64'(4));
        check("full_flag",   64'(stbuf_full), 64'(1));
        check("full_ready",  64'(bus.st_ready), 64'(0));
        check("full_starve", 64'(dut.starve_cnt), 64'(3));
        bus.ld_addr = 16'h004A;
        #1;
        check("full_fwd_data", 64'(bus.fwd_data), 64'h102);
        bus.lsu_freeze_dc3 = 1'b1;
        bus.ld_rden        = 1'b0;
        bus.st_valid       = 1'b1;
        bus.st_addr        = 16'h0060;
        bus.st_data        = 39'h66;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("freeze_wren_%0d", i),   64'(dccm_wren), 64'(0));
            check($sformatf("freeze_starve_%0d", i), 64'(dut.starve_cnt), 64'(3));
            step();
        end
        bus.st_valid = 1'b0;
        check("full_5th_count", 64'(stbuf_count), 64'(4));
        bus.lsu_freeze_dc3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("unfreeze_wren_%0d", i), 64'(dccm_wren), 64'(1));
            check($sformatf("unfreeze_addr_%0d", i), 64'(dccm_wr_addr), 64'h0040 + 64'(4 * i));
            check($sformatf("unfreeze_data_%0d", i), 64'(dccm_wr_data), 64'h100 + 64'(i));
            step();
        end
        check("unfreeze_empty", 64'(stbuf_empty), 64'(1));
        check("unfreeze_idle",  64'(dccm_wren), 64'(0));

        // async reset while draining with 3 entries held
        do_reset();
        bus.lsu_freeze_dc3 = 1'b1;
        push(16'h0070, 39'h77);
        push(16'h0074, 39'h78);
        push(16'h0078, 39'h79);
        check("mid_count", 64'(stbuf_count), 64'(3));
        bus.lsu_freeze_dc3 = 1'b0;
        bus.ld_addr        = 16'h0070;
        #1;
        check("mid_wren_pre", 64'(dccm_wren), 64'(1));
        rst_l = 1'b0;
        #1;
        check("mid_rst_wren",  64'(dccm_wren), 64'(0));
        check("mid_rst_count", 64'(stbuf_count), 64'(0));
        check("mid_rst_empty", 64'(stbuf_empty), 64'(1));
        check("mid_rst_fwd",   64'(bus.fwd_hit), 64'(0));
        rst_l = 1'b1;
        step();
        step();
        check("post_rst_wren",  64'(dccm_wren), 64'(0));
        check("post_rst_empty", 64'(stbuf_empty), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_dccm_stbuf.md
Name: lsu_dccm_stbuf

Overview:
Committed-store buffer directly upstream of the DCCM bank array. It holds word-wide (ECC-encoded) store writes and drains them into the single-ported DCCM write interface in cycles when the load pipe is not reading. It forwards buffered data to younger loads so that reads-after-write stay coherent. A starvation counter forces a drain, and stalls loads, if the buffer cannot make progress.

Parameters:
DEPTH, 4, number of store entries (power of 2, >=2)
ADDR_W, 16, DCCM byte address width (matches RV_DCCM_BITS)
DATA_W, 39, DCCM word width incl. ECC (matches RV_DCCM_FDATA_WIDTH)
STARVE_MAX, 8, consecutive blocked non-empty cycles before a forced drain

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
st_valid  in  1  committed store word presented
st_ready  out  1  buffer can accept a store this cycle
st_addr  in  ADDR_W  store byte address; bits [1:0] ignored (word-aligned)
st_data  in  DATA_W  full encoded store word
ld_rden  in  1  load pipe owns the DCCM read port this cycle
ld_addr  in  ADDR_W  load byte address for forwarding compare
fwd_hit  out  1  ld_addr word matches a buffered entry
fwd_data  out  DATA_W  data of the youngest matching entry
ld_stall  out  1  forced drain in progress; load pipe must hold
lsu_freeze_dc3  in  1  pipeline freeze; blocks all drains
dccm_wren  out  1  DCCM write enable
dccm_wr_addr  out  ADDR_W  DCCM write address
dccm_wr_data  out  DATA_W  DCCM write data
stbuf_empty  out  1  count==0
stbuf_full  out  1  count==DEPTH
stbuf_count  out  $clog2(DEPTH+1)  valid entries

Behaviour:
- Circular FIFO: wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap), count, and a per-entry valid bit, address [ADDR_W-1:2], and data.
- Reset (async, rst_l=0): pointers=0, count=0, valids=0, starve_cnt=0. Outputs: st_ready=1, stbuf_empty=1, stbuf_full=0, dccm_wren=0, dccm_wr_addr=0, dccm_wr_data=0, fwd_hit=0, fwd_data=0, ld_stall=0. Reset mid-drain discards all entries.
- Push: st_valid & st_ready at the clock edge writes the entry at wr_ptr, sets its valid bit, and increments wr_ptr.
- st_ready = ~stbuf_full. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- force = (starve_cnt == STARVE_MAX).
- Drain: dccm_wren = ~empty & ~lsu_freeze_dc3 & (~ld_rden | force). Combinational.
- When dccm_wren=1, dccm_wr_addr = {head addr, 2'b00} and dccm_wr_data = head data. When dccm_wren=0, both are 0.
- Pop on dccm_wren: clear the head valid bit and increment rd_ptr.
- Minimum store-to-DCCM latency is 1 cycle: an entry pushed at edge N can drain in cycle N+1.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full only if st_ready was 1 that cycle (so not when full).
- ld_stall = force & ~empty & ~lsu_freeze_dc3. It is asserted in the same cycle as the forced dccm_wren.
- starve_cnt:
  - Cleared when dccm_wren=1 or when empty.
  - Otherwise incremented, saturating at STARVE_MAX.
  - A freeze holds starve_cnt (no increment while lsu_freeze_dc3=1).
- Forwarding (combinational):
  - Compare ld_addr[ADDR_W-1:2] against every valid entry. The entry being popped this cycle still participates.
  - On multiple matches, the youngest (closest behind wr_ptr) wins.
  - A store being pushed this same cycle is NOT forwarded.
  - On a miss: fwd_hit=0 and fwd_data=0.
  - Forwarding is evaluated regardless of ld_rden.
- stbuf_count equals the number of set valid bits at all times. This is an assertion target.

Decomposition:
- Shared package lsu_stbuf_pkg:
  - typedef stbuf_entry_t {valid, addr[ADDR_W-1:2], data[DATA_W-1:0]}.
  - Localparams STBUF_PTR_W=$clog2(DEPTH) and STBUF_CNT_W=$clog2(DEPTH+1).
- One sub-module, lsu_stbuf_fwd: a combinational age-ordered CAM.
  - Inputs: entry array, rd_ptr, ld_addr.
  - Outputs: fwd_hit, fwd_data.
  - Rotates the match vector by rd_ptr and picks the highest-age match.
- Top level: FIFO, drain arbitration, and the starve counter.

Test Plan:
- Reset with rst_l pulsed low mid-run with 3 entries held -> count=0, empty=1, dccm_wren=0 asynchronously; no stale drain after release.
- Push addr 0x0010/data 0x1AB, ld_rden=0 -> next cycle dccm_wren=1, wr_addr=0x0010, wr_data=0x1AB; then empty=1.
- Push 4 stores with ld_rden=1 held -> full=1, st_ready=0. A 5th st_valid is not accepted and count stays 4.
- Stores to 0x0020 (data 0x11) then 0x0020 (data 0x22), ld_addr=0x0023 -> fwd_hit=1, fwd_data=0x22. ld_addr=0x0024 -> fwd_hit=0.
- One entry buffered, ld_rden=1 held -> after 8 blocked cycles: dccm_wren=1 and ld_stall=1 for exactly 1 cycle, then starve_cnt=0.
- Full buffer, ld_rden=0, lsu_freeze_dc3=1 for 5 cycles -> no dccm_wren and starve_cnt held. After freeze drops, one drain per cycle for 4 cycles.
